// File: rtl/draw_image_ctl.sv
// draw_image_ctl: overlays a ROM image at a frame-latched position onto a VGA stream via a 3-stage pipeline.
module draw_image_ctl #(
  parameter int          IMG_W   = 128,
  parameter int          IMG_H   = 128,
  parameter logic [11:0] KEY_RGB = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        en,
  output logic [13:0] rom_address,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  logic        r_vb_d;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_en;
  logic [37:0] r1_t;
  logic [37:0] r2_t;
  logic [25:0] r3_t;
  logic        r1_in;
  logic        r2_in;
  logic [13:0] r_addr;
  logic [11:0] r_rgb;
  logic        w_rise;
  logic [12:0] w_h;
  logic [12:0] w_v;
  logic [12:0] w_x;
  logic [12:0] w_y;
  logic        w_in;
  logic [6:0]  w_col;
  logic [6:0]  w_row;
  logic [13:0] w_addr;
  logic [11:0] w_rgb;

  assign w_rise = vblnk_in & ~r_vb_d;
  // 13-bit compares keep positions near 4095 from wrapping into range
  assign w_h = {2'b0, hcount_in};
  assign w_v = {2'b0, vcount_in};
  assign w_x = {1'b0, r_x};
  assign w_y = {1'b0, r_y};
  assign w_in = r_en & ~hblnk_in & ~vblnk_in
              & (w_h >= w_x) & (w_h < w_x + 13'(IMG_W))
              & (w_v >= w_y) & (w_v < w_y + 13'(IMG_H));
  assign w_col = (hcount_in[6:0] - r_x[6:0]) & 7'(IMG_W - 1);
  assign w_row = (vcount_in[6:0] - r_y[6:0]) & 7'(IMG_H - 1);
  assign w_addr = w_in ? {w_row, w_col} : 14'd0;
  assign w_rgb = (r2_in && rom_rgb != KEY_RGB) ? rom_rgb : r2_t[11:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vb_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_en   <= 1'b0;
      r1_t   <= '0;
      r2_t   <= '0;
      r3_t   <= '0;
      r1_in  <= 1'b0;
      r2_in  <= 1'b0;
      r_addr <= '0;
      r_rgb  <= '0;
    end else begin
      r_vb_d <= vblnk_in;
      if (w_rise) begin
        r_x  <= xpos;
        r_y  <= ypos;
        r_en <= en;
      end
      r1_t   <= {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in};
      r1_in  <= w_in;
      r_addr <= w_addr;
      r2_t   <= r1_t;
      r2_in  <= r1_in;
      r3_t   <= r2_t[37:12];
      r_rgb  <= w_rgb;
    end

  assign rom_address = r_addr;
  assign {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} = r3_t;
  assign rgb_out = r_rgb;
endmodule

// File: tb/tb_draw_image_ctl.sv
// tb_draw_image_ctl: directed vectors against a frame-level overlay model plus literal pinned expectations.
module tb_draw_image_ctl;
  localparam int          W   = 128;
  localparam int          H   = 128;
  localparam logic [11:0] KEY = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
  logic        en = 1'b0;
  logic [13:0] rom_address;
  logic [11:0] rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_image_ctl #(.IMG_W(W), .IMG_H(H), .KEY_RGB(KEY)) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .en(en),
    .rom_address(rom_address), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(logic [13:0] a);
    return (a[6:0] == 7'd5) ? KEY : (a[11:0] ^ 12'hA5C);
  endfunction

  always @(posedge clk) rom_rgb <= rom_f(rom_address);

  int lx = 0, ly = 0;
  bit len = 0, pv = 0, rst_v = 0;
  int nd = 0, errors = 0, checks = 0;
  logic [25:0] e_t [0:4095];
  logic [11:0] e_rgb [0:4095];
  logic [13:0] e_addr [0:4095];
  bit          e_r [0:4095];
  bit          pa_v [0:4095];
  logic [13:0] pa [0:4095];
  bit          pr_v [0:4095];
  logic [11:0] pr [0:4095];

  task automatic chk(string nm, logic [25:0] a, logic [25:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, nd - 1, a, e);
    end
  endtask

  task automatic cyc(int h, int v, bit hb, bit vb, logic [11:0] rgb);
    bit ins;
    int a;
    @(negedge clk);
    rst_n = rst_v;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in = hcount_in[4];
    vsync_in = vcount_in[1];
    hblnk_in = hb;
    vblnk_in = vb;
    rgb_in = rgb;
    ins = 0;
    if (!rst_v) begin
      lx = 0; ly = 0; len = 0; pv = 0;
    end else begin
      ins = len && !hb && !vb && h >= lx && h < lx + W && v >= ly && v < ly + H;
      if (vb && !pv) begin
        lx = int'(xpos); ly = int'(ypos); len = en;
      end
      pv = vb;
    end
    a = ins ? ((v - ly) % H) * 128 + (h - lx) % W : 0;
    e_t[nd] = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};
    e_addr[nd] = 14'(a);
    e_rgb[nd] = (ins && rom_f(14'(a)) != KEY) ? rom_f(14'(a)) : rgb;
    e_r[nd] = rst_v;
    pa_v[nd] = 0;
    pr_v[nd] = 0;
    nd++;
  endtask

  task automatic pin_a(logic [13:0] v);
    pa_v[nd - 1] = 1; pa[nd - 1] = v;
  endtask

  task automatic pin_r(logic [11:0] v);
    pr_v[nd - 1] = 1; pr[nd - 1] = v;
  endtask

  task automatic vblank();
    cyc(0, 600, 1, 0, 12'h000);
    cyc(0, 601, 1, 1, 12'h000);
    cyc(0, 602, 1, 1, 12'h000);
  endtask

  task automatic line(int v, int h0, int h1);
    for (int h = h0; h <= h1; h++) cyc(h, v, 0, 0, 12'($urandom));
  endtask

  logic [25:0] w_tout;
  assign w_tout = {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out};

  always begin
    int n;
    @(posedge clk);
    #1;
    if (nd > 0) begin
      n = nd - 1;
      if (!rst_n) begin
        chk("reset_addr", 26'(rom_address), 26'd0);
        chk("reset_timing", w_tout, 26'd0);
        chk("reset_rgb", 26'(rgb_out), 26'd0);
      end else begin
        chk("rom_address", 26'(rom_address), 26'(e_addr[n]));
        if (n >= 2 && e_r[n - 2] && e_r[n - 1]) begin
          chk("timing_out", w_tout, e_t[n - 2]);
          chk("rgb_out", 26'(rgb_out), 26'(e_rgb[n - 2]));
          if (pr_v[n - 2]) chk("pin_rgb", 26'(rgb_out), 26'(pr[n - 2]));
        end else begin
          chk("post_reset_timing", w_tout, 26'd0);
          chk("post_reset_rgb", 26'(rgb_out), 26'd0);
        end
        if (pa_v[n]) chk("pin_addr", 26'(rom_address), 26'(pa[n]));
      end
    end
  end

  initial begin
    xpos = 12'd100; ypos = 12'd50; en = 1'b1;
    repeat (3) cyc(5, 5, 0, 0, 12'hFFF);
    rst_v = 1;
    repeat (3) cyc(7, 7, 0, 0, 12'($urandom));
    vblank();
    line(50, 96, 99);
    cyc(100, 50, 0, 0, 12'h321); pin_a(14'h0000); pin_r(12'hA5C);
    line(50, 101, 104);
    cyc(105, 50, 0, 0, 12'h123); pin_a(14'h0005); pin_r(12'h123);
    line(50, 106, 108);
    line(177, 224, 226);
    cyc(227, 177, 0, 0, 12'h777); pin_a(14'h3FFF); pin_r(12'h5A3);
    cyc(228, 177, 0, 0, 12'h456); pin_a(14'h0000); pin_r(12'h456);
    cyc(229, 177, 0, 0, 12'h654);
    cyc(100, 49, 0, 0, 12'h111); pin_a(14'h0000);
    cyc(100, 178, 0, 0, 12'h222); pin_a(14'h0000);
    xpos = 12'd300;
    line(60, 98, 99);
    cyc(100, 60, 0, 0, 12'h333); pin_a(14'h0500);
    line(60, 298, 299);
    cyc(300, 60, 0, 0, 12'h444); pin_a(14'h0000); pin_r(12'h444);
    vblank();
    cyc(100, 60, 0, 0, 12'h555); pin_a(14'h0000); pin_r(12'h555);
    line(60, 298, 299);
    cyc(300, 60, 0, 0, 12'h666); pin_a(14'h0500);
    line(60, 301, 302);
    xpos = 12'd4090; ypos = 12'd0;
    vblank();
    foreach (e_t[i]) if (i < 8) begin
      cyc(i * 293, i * 7, 0, 0, 12'(i * 111)); pin_a(14'h0000); pin_r(12'(i * 111));
    end
    cyc(2047, 0, 0, 0, 12'h0AB); pin_a(14'h0000); pin_r(12'h0AB);
    xpos = 12'd960; ypos = 12'd0;
    vblank();
    for (int h = 1018; h <= 1027; h++) cyc(h, 0, h >= 1024, 0, 12'($urandom));
    cyc(1023, 3, 0, 0, 12'h010); pin_a(14'h01BF);
    cyc(1024, 3, 1, 0, 12'h789); pin_a(14'h0000); pin_r(12'h789);
    xpos = 12'd100; ypos = 12'd50;
    cyc(0, 600, 1, 0, 12'h000);
    cyc(100, 50, 0, 1, 12'h0CC); pin_a(14'h0000); pin_r(12'h0CC);
    cyc(101, 50, 0, 0, 12'h0DD); pin_a(14'h0001);
    line(50, 102, 104);
    rst_v = 0;
    cyc(106, 50, 0, 0, 12'h0EE);
    #1;
    chk("async_reset_rgb", 26'(rgb_out), 26'd0);
    chk("async_reset_timing", w_tout, 26'd0);
    chk("async_reset_addr", 26'(rom_address), 26'd0);
    cyc(107, 50, 0, 0, 12'h0EF);
    rst_v = 1;
    line(50, 108, 109);
    cyc(110, 50, 0, 0, 12'h0F1); pin_a(14'h0000); pin_r(12'h0F1);
    line(50, 111, 113);
    vblank();
    line(50, 100, 100);
    cyc(101, 50, 0, 0, 12'h0F2); pin_a(14'h0001);
    line(50, 102, 104);
    repeat (4) cyc(0, 0, 1, 0, 12'h000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
